// File: rtl/perf_dump_if.sv
// Word stream from the counter dump engine to its consumer.
// Plain valid/ready handshake carrying data, CSR address and last flag.
interface perf_dump_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [11:0] out_addr;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/perf_dump.sv
// Reads the hpm counter block over CSR reads and streams lo/hi words.
// Optional PERF_DUMP_ID_EN prefixes the dump with MVENDORID/MARCHID/MISA.
module perf_dump (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] csr_addr,
  input  logic [31:0] csr_rdata,
  perf_dump_if.master strm,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE    = 3'd0;
`ifdef PERF_DUMP_ID_EN
  localparam logic [2:0] ID      = 3'd1;
`endif
  localparam logic [2:0] RD_HI   = 3'd2;
  localparam logic [2:0] RD_LO   = 3'd3;
  localparam logic [2:0] RD_HI2  = 3'd4;
  localparam logic [2:0] EMIT_LO = 3'd5;
  localparam logic [2:0] EMIT_HI = 3'd6;
  localparam logic [2:0] FIN     = 3'd7;

  localparam logic [3:0] LAST_PTR = 4'd9;

  logic [2:0]  state;
  logic [3:0]  ptr;
  logic [31:0] hi_a;
  logic [31:0] lo;
  logic [6:0]  idx;
  logic [11:0] lo_addr;
  logic [11:0] hi_addr;

`ifdef PERF_DUMP_ID_EN
  logic [1:0]  id_ptr;
  logic        id_emit;
  logic [11:0] id_addr;

  always_comb begin
    unique case (id_ptr)
      2'd0:    id_addr = 12'hF11;
      2'd1:    id_addr = 12'hF12;
      default: id_addr = 12'h301;
    endcase
  end
`endif

  // counter 1 (mtime alias) is not dumped, so the list skips it
  assign idx     = (ptr == 4'd0) ? 7'd0 : ({3'b000, ptr} + 7'd1);
  assign lo_addr = {5'b10110, idx};
  assign hi_addr = {5'b10111, idx};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 4'd0;
      hi_a  <= 32'd0;
      lo    <= 32'd0;
`ifdef PERF_DUMP_ID_EN
      id_ptr  <= 2'd0;
      id_emit <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ptr <= 4'd0;
`ifdef PERF_DUMP_ID_EN
            id_ptr  <= 2'd0;
            id_emit <= 1'b0;
            state   <= ID;
`else
            state <= RD_HI;
`endif
          end
        end
`ifdef PERF_DUMP_ID_EN
        ID: begin
          if (!id_emit) begin
            lo      <= csr_rdata;
            id_emit <= 1'b1;
          end else if (strm.out_ready) begin
            id_emit <= 1'b0;
            if (id_ptr == 2'd2) begin
              id_ptr <= 2'd0;
              state  <= RD_HI;
            end else begin
              id_ptr <= id_ptr + 2'd1;
            end
          end
        end
`endif
        RD_HI: begin
          hi_a  <= csr_rdata;
          state <= RD_LO;
        end
        RD_LO: begin
          lo    <= csr_rdata;
          state <= RD_HI2;
        end
        RD_HI2: begin
          // hi moved under us: lo may have wrapped, so reread it
          if (csr_rdata == hi_a) begin
            state <= EMIT_LO;
          end else begin
            hi_a  <= csr_rdata;
            state <= RD_LO;
          end
        end
        EMIT_LO: begin
          if (strm.out_ready) state <= EMIT_HI;
        end
        EMIT_HI: begin
          if (strm.out_ready) begin
            if (ptr == LAST_PTR) begin
              state <= FIN;
            end else begin
              ptr   <= ptr + 4'd1;
              state <= RD_HI;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    csr_addr       = 12'h000;
    strm.out_valid = 1'b0;
    strm.out_data  = 32'd0;
    strm.out_addr  = 12'h000;
    strm.out_last  = 1'b0;
    unique case (state)
`ifdef PERF_DUMP_ID_EN
      ID: begin
        if (!id_emit) begin
          csr_addr = id_addr;
        end else begin
          strm.out_valid = 1'b1;
          strm.out_data  = lo;
          strm.out_addr  = id_addr;
        end
      end
`endif
      RD_HI:  csr_addr = hi_addr;
      RD_LO:  csr_addr = lo_addr;
      RD_HI2: csr_addr = hi_addr;
      EMIT_LO: begin
        strm.out_valid = 1'b1;
        strm.out_data  = lo;
        strm.out_addr  = lo_addr;
      end
      EMIT_HI: begin
        strm.out_valid = 1'b1;
        strm.out_data  = hi_a;
        strm.out_addr  = hi_addr;
        strm.out_last  = (ptr == LAST_PTR);
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_perf_dump.sv
// Directed bench for perf_dump: CSR counter model, stream monitor,
// expected-word table plus hand sequences for stall, race and reset.
module tb_perf_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  perf_dump_if strm();

  perf_dump dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
    .csr_addr  (csr_addr),
    .csr_rdata (csr_rdata),
    .strm      (strm),
    .busy      (busy),
    .done      (done)
  );

`ifdef PERF_DUMP_ID_EN
  localparam int NID = 3;
`else
  localparam int NID = 0;
`endif
  localparam int NW = NID + 20;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [63:0] cnt;
    word_t       lo_w;
    word_t       hi_w;
  } vec_t;

  vec_t  tbl [10];
  word_t exp_w [NW];

  logic  race = 1'b0;
  int    hr = 0;
  int    lr = 0;
  logic  clr_mon = 1'b0;
  word_t got [$];
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    acc_cyc = 0;
  int    busy_cyc = 0;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    csr_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      if (csr_addr == tbl[i].lo_w.addr) csr_rdata = tbl[i].cnt[31:0];
      if (csr_addr == tbl[i].hi_w.addr) csr_rdata = tbl[i].cnt[63:32];
    end
    if (race && csr_addr == 12'hB80)
      csr_rdata = (hr == 0) ? 32'h0 : 32'h1;
    if (race && csr_addr == 12'hB00)
      csr_rdata = (lr == 0) ? 32'hFFFF_FFFF : 32'h2;
    if (csr_addr == 12'hF11) csr_rdata = 32'h616B_6562;
    if (csr_addr == 12'hF12) csr_rdata = 32'h0531_8008;
    if (csr_addr == 12'h301) csr_rdata = 32'h4000_0010;
  end

  // per-address read counts drive the carry-race sequence
  always @(posedge clk) begin
    if (!race) begin
      hr <= 0;
      lr <= 0;
    end else begin
      if (csr_addr == 12'hB80) hr <= hr + 1;
      if (csr_addr == 12'hB00) lr <= lr + 1;
    end
  end

  always @(negedge clk) begin
    if (clr_mon) begin
      got.delete();
      done_cnt <= 0;
      busy_cyc <= 0;
    end else begin
      if (strm.out_valid && strm.out_ready) begin
        got.push_back('{strm.out_addr, strm.out_data, strm.out_last});
        acc_cyc <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy && !done) busy_cyc <= busy_cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge clk);
    #1;
    clr_mon = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk("done_within_budget", 64'(done), 64'd1);
    tick();
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_valid"}, 64'(strm.out_valid), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_csr_addr"}, 64'(csr_addr), 64'd0);
    chk({nm, "_last"}, 64'(strm.out_last), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int    k;
    int    n0;
    word_t g;
    word_t snap;
    logic [6:0] ix;

    // counter table: entry index -> CSR idx, value, expected words
    for (int i = 0; i < 10; i++) begin
      ix = (i == 0) ? 7'd0 : 7'(i + 1);
      tbl[i].cnt = {32'h0000_1000 + 32'(i), 32'hA5A5_0000 + 32'(3 * i)};
      tbl[i].lo_w = '{12'hB00 + 12'(ix), tbl[i].cnt[31:0], 1'b0};
      tbl[i].hi_w = '{12'hB80 + 12'(ix), tbl[i].cnt[63:32], i == 9};
    end
    tbl[0].cnt = 64'h0000_0001_0000_0005;
    tbl[0].lo_w.data = 32'h0000_0005;
    tbl[0].hi_w.data = 32'h0000_0001;
`ifdef PERF_DUMP_ID_EN
    exp_w[0] = '{12'hF11, 32'h616B_6562, 1'b0};
    exp_w[1] = '{12'hF12, 32'h0531_8008, 1'b0};
    exp_w[2] = '{12'h301, 32'h4000_0010, 1'b0};
`endif
    for (int i = 0; i < 10; i++) begin
      exp_w[NID + 2 * i]     = tbl[i].lo_w;
      exp_w[NID + 2 * i + 1] = tbl[i].hi_w;
    end

    reset = 1'b1;
    start = 1'b0;
    strm.out_ready = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b0;
    clear_mon();

    // static dump, consumer always ready
    pulse_start();
`ifdef PERF_DUMP_ID_EN
    chk("first_csr_addr", 64'(csr_addr), 64'h F11);
`else
    chk("first_csr_addr", 64'(csr_addr), 64'h B80);
`endif
    chk("busy_after_start", 64'(busy), 64'd1);
    run_to_done(300);
    tick();
    chk("word_count", 64'(got.size()), 64'(NW));
    for (int i = 0; i < NW; i++) begin
      g = (i < got.size()) ? got[i] : '0;
      chk($sformatf("word%0d", i), 64'(g), 64'(exp_w[i]));
    end
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("done_after_last", 64'(done_cyc), 64'(acc_cyc + 1));
    chk("busy_cycles", 64'(busy_cyc), 64'(50 + 2 * NID));
    chk_idle("after_dump");

    // first word held under backpressure for 7 cycles
    clear_mon();
    strm.out_ready = 1'b0;
    pulse_start();
    k = 0;
    while (!strm.out_valid && k < 50) begin
      tick();
      k++;
    end
    chk("stall_valid_seen", 64'(strm.out_valid), 64'd1);
    snap = '{strm.out_addr, strm.out_data, strm.out_last};
    chk("stall_first_word", 64'(snap), 64'(exp_w[0]));
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("stall_valid%0d", i), 64'(strm.out_valid), 64'd1);
      chk($sformatf("stall_word%0d", i),
          64'({strm.out_addr, strm.out_data, strm.out_last}), 64'(snap));
      tick();
    end
    chk("stall_nothing_accepted", 64'(got.size()), 64'd0);
    strm.out_ready = 1'b1;
    tick();
    chk("stall_one_accepted", 64'(got.size()), 64'd1);
    g = (got.size() > 0) ? got[0] : '0;
    chk("stall_accepted_word", 64'(g), 64'(exp_w[0]));
    run_to_done(300);
    tick();
    chk("stall_word_count", 64'(got.size()), 64'(NW));

    // hi carries between the two hi reads: one retry of lo
    clear_mon();
    race = 1'b1;
    pulse_start();
    run_to_done(300);
    tick();
    race = 1'b0;
    chk("race_word_count", 64'(got.size()), 64'(NW));
    g = (got.size() > NID) ? got[NID] : '0;
    chk("race_lo", 64'(g), 64'({12'hB00, 32'h0000_0002, 1'b0}));
    g = (got.size() > NID + 1) ? got[NID + 1] : '0;
    chk("race_hi", 64'(g), 64'({12'hB80, 32'h0000_0001, 1'b0}));

    // start held high through the whole dump including FIN
    clear_mon();
    start = 1'b1;
    tick();
    k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    chk("hold_done_seen", 64'(done), 64'd1);
    tick();
    chk("hold_idle_after_fin", 64'(busy), 64'd0);
    tick();
    chk("hold_restart_from_idle", 64'(busy), 64'd1);
    chk("hold_word_count", 64'(got.size()), 64'(NW));
    chk("hold_done_count", 64'(done_cnt), 64'd1);
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // reset in EMIT_HI of entry 4 abandons the dump
    clear_mon();
    pulse_start();
    k = 0;
    while (!(strm.out_valid && strm.out_addr == 12'hB85) && k < 300) begin
      tick();
      k++;
    end
    chk("rst_reached_entry4_hi", 64'(strm.out_addr), 64'h B85);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rst_mid");
    tick();
    tick();
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    chk("rst_still_idle", 64'(busy), 64'd0);
    n0 = got.size();
    pulse_start();
    k = 0;
    while (got.size() <= n0 + NID && k < 100) begin
      tick();
      k++;
    end
    g = (got.size() > n0 + NID) ? got[n0 + NID] : '0;
    chk("rst_restart_addr", 64'(g.addr), 64'h B00);
    run_to_done(300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
